// File: rtl/lc3bp_pipe_ctrl.sv
// Pipeline latches for the post-decode stages of the LC3B core, with the
// register/CC dependency stall, the control-instruction stall and retire/bubble counters.
module lc3bp_pipe_ctrl #(
    parameter int STAGES      = 3,
    parameter int PAY_W       = 64,
    parameter int RID_W       = 3,
    parameter int STALL_STAGE = 1,
    parameter int SR_BYPASS   = 0,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    de_v,
    input  logic [PAY_W-1:0]        de_payload,
    input  logic                    de_ld_reg,
    input  logic [RID_W-1:0]        de_drid,
    input  logic                    de_ld_cc,
    input  logic                    de_br,
    input  logic                    de_sr1_needed,
    input  logic [RID_W-1:0]        de_sr1,
    input  logic                    de_sr2_needed,
    input  logic [RID_W-1:0]        de_sr2,
    input  logic                    de_cc_needed,
    input  logic                    mem_stall,
    input  logic                    flush,
    output logic                    dep_stall,
    output logic                    br_stall,
    output logic                    de_accept,
    output logic [STAGES-1:0]       stage_v,
    output logic [STAGES*PAY_W-1:0] stage_payload,
    output logic                    out_v,
    output logic                    out_ld_reg,
    output logic                    out_ld_cc,
    output logic [RID_W-1:0]        out_drid,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);
    localparam int LAST = STAGES - 1;
    // With a write-through register file the last stage never causes a RAW stall.
    localparam int CHK_LAST = (SR_BYPASS != 0) ? STAGES - 2 : STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ld_reg_q;
    logic [STAGES-1:0] ld_cc_q;
    logic [STAGES-1:0] br_q;
    logic [PAY_W-1:0]  pay_q  [STAGES];
    logic [RID_W-1:0]  drid_q [STAGES];
    logic [CNT_W-1:0]  retire_q;
    logic [CNT_W-1:0]  bubble_q;
    logic              hazard;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i <= CHK_LAST; i++) begin
            if (v_q[i]) begin
                if (de_sr1_needed && ld_reg_q[i] && (drid_q[i] == de_sr1)) hazard = 1'b1;
                if (de_sr2_needed && ld_reg_q[i] && (drid_q[i] == de_sr2)) hazard = 1'b1;
                if (de_cc_needed && ld_cc_q[i]) hazard = 1'b1;
            end
        end
    end

    assign dep_stall = de_v && hazard;
    assign br_stall  = (de_v && de_br) || (|(v_q & br_q));
    assign de_accept = de_v && !dep_stall && !mem_stall && !flush;

    // Stages at or below STALL_STAGE freeze under mem_stall; the one above takes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q      <= '0;
            ld_reg_q <= '0;
            ld_cc_q  <= '0;
            br_q     <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pay_q[i]  <= '0;
                drid_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                if (!(mem_stall && (i <= STALL_STAGE))) begin
                    v_q[i]      <= (mem_stall && (i == STALL_STAGE + 1)) ? 1'b0 : v_q[i-1];
                    ld_reg_q[i] <= ld_reg_q[i-1];
                    ld_cc_q[i]  <= ld_cc_q[i-1];
                    br_q[i]     <= br_q[i-1];
                    pay_q[i]    <= pay_q[i-1];
                    drid_q[i]   <= drid_q[i-1];
                end
            end
            if (!mem_stall) begin
                v_q[0]      <= de_accept;
                ld_reg_q[0] <= de_ld_reg;
                ld_cc_q[0]  <= de_ld_cc;
                br_q[0]     <= de_br;
                pay_q[0]    <= de_payload;
                drid_q[0]   <= de_drid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            if (v_q[LAST] && !(&retire_q)) retire_q <= retire_q + CNT_W'(1);
            if (dep_stall && !mem_stall && !flush && !(&bubble_q)) bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    always_comb begin
        stage_payload = '0;
        for (int i = 0; i < STAGES; i++) stage_payload[i*PAY_W +: PAY_W] = pay_q[i];
    end

    assign stage_v    = v_q;
    assign out_v      = v_q[LAST];
    assign out_ld_reg = v_q[LAST] && ld_reg_q[LAST];
    assign out_ld_cc  = v_q[LAST] && ld_cc_q[LAST];
    assign out_drid   = drid_q[LAST];
    assign retire_cnt = retire_q;
    assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_lc3bp_pipe_ctrl.sv
// Directed bench for lc3bp_pipe_ctrl: hazard/stall timing checks plus a retire-order scoreboard.
module tb_lc3bp_pipe_ctrl;
    localparam int ST = 3;
    localparam int PW = 16;
    localparam int RW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          de_v = 1'b0;
    logic [PW-1:0] de_payload = '0;
    logic          de_ld_reg = 1'b0;
    logic [RW-1:0] de_drid = '0;
    logic          de_ld_cc = 1'b0;
    logic          de_br = 1'b0;
    logic          de_sr1_needed = 1'b0;
    logic [RW-1:0] de_sr1 = '0;
    logic          de_sr2_needed = 1'b0;
    logic [RW-1:0] de_sr2 = '0;
    logic          de_cc_needed = 1'b0;
    logic          mem_stall = 1'b0;
    logic          flush = 1'b0;

    logic             dep_stall, br_stall, de_accept, out_v, out_ld_reg, out_ld_cc;
    logic [ST-1:0]    stage_v;
    logic [ST*PW-1:0] stage_payload;
    logic [RW-1:0]    out_drid;
    logic [CW-1:0]    retire_cnt, bubble_cnt;

    logic             b_dep_stall, b_br_stall, b_de_accept, b_out_v, b_out_ld_reg, b_out_ld_cc;
    logic [ST-1:0]    b_stage_v;
    logic [ST*PW-1:0] b_stage_payload;
    logic [RW-1:0]    b_out_drid;
    logic [CW-1:0]    b_retire_cnt, b_bubble_cnt;

    logic [PW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3bp_pipe_ctrl #(.STAGES(ST), .PAY_W(PW), .RID_W(RW), .STALL_STAGE(1),
                      .SR_BYPASS(0), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .de_v(de_v), .de_payload(de_payload),
        .de_ld_reg(de_ld_reg), .de_drid(de_drid), .de_ld_cc(de_ld_cc), .de_br(de_br),
        .de_sr1_needed(de_sr1_needed), .de_sr1(de_sr1), .de_sr2_needed(de_sr2_needed),
        .de_sr2(de_sr2), .de_cc_needed(de_cc_needed), .mem_stall(mem_stall), .flush(flush),
        .dep_stall(dep_stall), .br_stall(br_stall), .de_accept(de_accept),
        .stage_v(stage_v), .stage_payload(stage_payload), .out_v(out_v),
        .out_ld_reg(out_ld_reg), .out_ld_cc(out_ld_cc), .out_drid(out_drid),
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    lc3bp_pipe_ctrl #(.STAGES(ST), .PAY_W(PW), .RID_W(RW), .STALL_STAGE(1),
                      .SR_BYPASS(1), .CNT_W(CW)) dut_byp (
        .clk(clk), .reset(reset), .de_v(de_v), .de_payload(de_payload),
        .de_ld_reg(de_ld_reg), .de_drid(de_drid), .de_ld_cc(de_ld_cc), .de_br(de_br),
        .de_sr1_needed(de_sr1_needed), .de_sr1(de_sr1), .de_sr2_needed(de_sr2_needed),
        .de_sr2(de_sr2), .de_cc_needed(de_cc_needed), .mem_stall(mem_stall), .flush(flush),
        .dep_stall(b_dep_stall), .br_stall(b_br_stall), .de_accept(b_de_accept),
        .stage_v(b_stage_v), .stage_payload(b_stage_payload), .out_v(b_out_v),
        .out_ld_reg(b_out_ld_reg), .out_ld_cc(b_out_ld_cc), .out_drid(b_out_drid),
        .retire_cnt(b_retire_cnt), .bubble_cnt(b_bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        de_v = 1'b0; de_payload = '0; de_ld_reg = 1'b0; de_drid = '0; de_ld_cc = 1'b0;
        de_br = 1'b0; de_sr1_needed = 1'b0; de_sr1 = '0; de_sr2_needed = 1'b0;
        de_sr2 = '0; de_cc_needed = 1'b0;
    endtask

    task automatic drive(input logic [PW-1:0] pay, input logic ldreg, input logic [RW-1:0] drid,
                         input logic ldcc, input logic br, input logic s1n, input logic [RW-1:0] s1,
                         input logic s2n, input logic [RW-1:0] s2, input logic ccn);
        de_v = 1'b1; de_payload = pay; de_ld_reg = ldreg; de_drid = drid; de_ld_cc = ldcc;
        de_br = br; de_sr1_needed = s1n; de_sr1 = s1; de_sr2_needed = s2n; de_sr2 = s2;
        de_cc_needed = ccn;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_stall = 1'b0; flush = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Retire monitor: every valid last-stage cycle must match the oldest expected payload.
    always @(negedge clk) begin
        if (!reset && out_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL retire_unexpected: observed=%0h expected=none", stage_payload[(ST-1)*PW +: PW]);
            end else begin
                check("retire_payload", stage_payload[(ST-1)*PW +: PW], exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_stage_v", stage_v, 0);
        check("rst_out_v", out_v, 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_dep", dep_stall, 0);
        check("rst_br", br_stall, 0);

        // Four independent instructions
        for (int i = 0; i < 4; i++) begin
            drive(16'h1000 + 16'(i), 1'b1, RW'(i), 1'b0, 1'b0, 1'b1, RW'(4 + i), 1'b1, RW'(4 + ((i + 1) % 4)), 1'b0);
            #1;
            check("t1_dep", dep_stall, 0);
            check("t1_accept", de_accept, 1);
            exp_q.push_back(16'h1000 + 16'(i));
            if (i == 2) begin
                check("t1_stage_v", stage_v, 3'b011);
                check("t1_out_v_early", out_v, 0);
            end
            if (i == 3) begin
                check("t1_out_v", out_v, 1);
                check("t1_out_drid", out_drid, 0);
                check("t1_out_ld_reg", out_ld_reg, 1);
            end
            tick();
        end
        idle();
        tick(); tick(); tick();
        #1;
        check("t1_retire_cnt", retire_cnt, 4);
        check("t1_empty", stage_v, 0);
        drain();

        // RAW on R2: 3 bubbles, 2 when the last stage writes through
        do_reset();
        drive(16'h2000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        #1;
        check("t2_accept_a", de_accept, 1);
        exp_q.push_back(16'h2000);
        tick();
        drive(16'h2001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("t2_dep", dep_stall, 1);
            check("t2_no_accept", de_accept, 0);
            check("t2_byp_dep", b_dep_stall, (k < 3) ? 1 : 0);
            tick();
        end
        #1;
        check("t2_dep_clear", dep_stall, 0);
        check("t2_accept_b", de_accept, 1);
        check("t2_bubble_cnt", bubble_cnt, 3);
        exp_q.push_back(16'h2001);
        tick();
        drive(16'h2002, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
        #1;
        check("t2_self_dep", dep_stall, 0);
        exp_q.push_back(16'h2002);
        tick();
        drive(16'h2003, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
        de_v = 1'b0;
        #1;
        check("t2_nov_dep", dep_stall, 0);
        check("t2_nov_br", br_stall, 0);
        tick();
        drain();

        // CC producer then BR
        do_reset();
        drive(16'h3000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        #1;
        check("t3_accept_cc", de_accept, 1);
        check("t3_br_idle", br_stall, 0);
        exp_q.push_back(16'h3000);
        tick();
        drive(16'h3001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("t3_dep", dep_stall, 1);
            check("t3_br", br_stall, 1);
            tick();
        end
        #1;
        check("t3_dep_clear", dep_stall, 0);
        check("t3_accept_br", de_accept, 1);
        check("t3_br_decode", br_stall, 1);
        exp_q.push_back(16'h3001);
        tick();
        idle();
        for (int k = 5; k <= 7; k++) begin
            #1;
            check("t3_br_flight", br_stall, 1);
            tick();
        end
        #1;
        check("t3_br_drop", br_stall, 0);
        drain();

        // mem_stall for two cycles
        do_reset();
        drive(16'h4000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        exp_q.push_back(16'h4000);
        tick();
        drive(16'h4001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        exp_q.push_back(16'h4001);
        tick();
        drive(16'h4002, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        mem_stall = 1'b1;
        #1;
        check("t4_accept_ms0", de_accept, 0);
        check("t4_stage_v0", stage_v, 3'b011);
        tick();
        #1;
        check("t4_accept_ms1", de_accept, 0);
        check("t4_stage_v1", stage_v, 3'b011);
        check("t4_pay0_hold", stage_payload[0 +: PW], 16'h4001);
        check("t4_pay1_hold", stage_payload[PW +: PW], 16'h4000);
        tick();
        mem_stall = 1'b0;
        #1;
        check("t4_stage_v2", stage_v, 3'b011);
        check("t4_pay0_hold2", stage_payload[0 +: PW], 16'h4001);
        check("t4_pay1_hold2", stage_payload[PW +: PW], 16'h4000);
        check("t4_accept_resume", de_accept, 1);
        exp_q.push_back(16'h4002);
        tick();
        idle();
        #1;
        check("t4_full", stage_v, 3'b111);
        drain();

        // Flush with everything valid and mem_stall asserted
        do_reset();
        drive(16'h5000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        exp_q.push_back(16'h5000);
        tick();
        drive(16'h5001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        exp_q.push_back(16'h5001);
        tick();
        drive(16'h5002, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        exp_q.push_back(16'h5002);
        tick();
        drive(16'h5003, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
        mem_stall = 1'b1;
        flush = 1'b1;
        #1;
        check("t5_full", stage_v, 3'b111);
        check("t5_br", br_stall, 1);
        check("t5_dep", dep_stall, 1);
        check("t5_accept", de_accept, 0);
        tick();
        exp_q.delete();
        mem_stall = 1'b0;
        flush = 1'b0;
        #1;
        check("t5_flushed", stage_v, 0);
        check("t5_br_drop", br_stall, 0);
        check("t5_dep_drop", dep_stall, 0);
        check("t5_accept_after", de_accept, 1);
        check("t5_bubble_cnt", bubble_cnt, 0);
        exp_q.push_back(16'h5003);
        tick();
        drain();

        // Counter saturation, then a reset pulse mid-stream
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(16'h6000 + 16'(i), 1'b0, RW'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            #1;
            check("t6_accept", de_accept, 1);
            exp_q.push_back(16'h6000 + 16'(i));
            tick();
        end
        idle();
        tick(); tick(); tick();
        #1;
        check("t6_retire_sat", retire_cnt, 15);
        for (int i = 0; i < 3; i++) begin
            drive(16'h6100 + 16'(i), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            exp_q.push_back(16'h6100 + 16'(i));
            tick();
        end
        drive(16'h6103, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        exp_q.delete();
        #1;
        check("t6_rst_stage_v", stage_v, 0);
        check("t6_rst_retire", retire_cnt, 0);
        check("t6_rst_bubble", bubble_cnt, 0);
        check("t6_rst_out_v", out_v, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lc3bp_pipe_ctrl.md
Name: lc3bp_pipe_ctrl

Overview:
Parametrised pipeline-latch and hazard controller for the LC3B pipelined core. It holds the per-instruction control state for every stage after decode (AGEX, MEM, SR by default). It advances that state under stall, bubble and flush rules, and produces the register/CC dependency stall and the control-instruction stall. Decode feeds it; the top level replaces its hand-written AGEX/MEM/SR latch blocks with one instance.

Parameters:
STAGES, 3, number of post-decode stages (index 0 = AGEX, STAGES-1 = SR); legal 2..8
PAY_W, 64, width of the opaque per-stage payload (NPC, IR, CS, operands)
RID_W, 3, register-ID width
STALL_STAGE, 1, index of the stage that owns mem_stall (MEM); must be < STAGES-1
SR_BYPASS, 0, 1 = the last stage does not count in dependency checks (register file writes through)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high
de_v  in  1  decode latch holds a valid instruction
de_payload  in  PAY_W  payload to latch into stage 0
de_ld_reg  in  1  instruction writes a register
de_drid  in  RID_W  destination register
de_ld_cc  in  1  instruction writes CC
de_br  in  1  instruction is a control instruction (BR/JMP/JSR/TRAP)
de_sr1_needed  in  1  SR1 is read
de_sr1  in  RID_W  SR1 ID
de_sr2_needed  in  1  SR2 is read
de_sr2  in  RID_W  SR2 ID
de_cc_needed  in  1  instruction reads CC (BR)
mem_stall  in  1  stage STALL_STAGE cannot complete this cycle
flush  in  1  squash all in-flight stages
dep_stall  out  1  decode must hold: RAW hazard
br_stall  out  1  fetch must hold: control instruction in decode or in flight
de_accept  out  1  stage 0 latches the decode instruction this cycle
stage_v  out  STAGES  valid bit per stage
stage_payload  out  STAGES*PAY_W  concatenated payloads, stage 0 in LSBs
out_v  out  1  = stage_v[STAGES-1]
out_ld_reg  out  1  last-stage ld_reg AND out_v
out_ld_cc  out  1  last-stage ld_cc AND out_v
out_drid  out  RID_W  last-stage DRID
retire_cnt  out  CNT_W  saturating count of valid last-stage cycles
bubble_cnt  out  CNT_W  saturating count of dep_stall bubbles inserted

Behaviour:
- Per-stage state: V, PAY, LDREG, DRID, LDCC, BR.
- Reset: all fields 0; counters 0. All outputs therefore read 0; dep_stall/br_stall are 0 while de_v=0.
- Check set C = valid stages 0..STAGES-1, or 0..STAGES-2 if SR_BYPASS=1.
- dep_stall (combinational) = de_v AND (any of):
  - de_sr1_needed and some stage in C has LDREG=1 with DRID==de_sr1
  - the same test for SR2
  - de_cc_needed and some stage in C has LDCC=1
- br_stall (combinational) = (de_v AND de_br) OR any valid stage with BR=1. It drops the cycle after the control instruction leaves the last stage.
- de_accept = de_v AND NOT dep_stall AND NOT mem_stall AND NOT flush.
- Advance per posedge, with priority reset > flush > normal:
  - flush: every V <= 0. Other fields are don't-care and are held.
  - mem_stall=1: stages 0..STALL_STAGE hold all fields. Stage STALL_STAGE+1 gets V=0 (bubble). Stages above it shift normally.
  - mem_stall=0: stage i+1 <= stage i for all i. Stage 0 <= decode fields with V=de_accept; if not accepted, V=0 (bubble) and the payload still loads.
- Latency: an accepted instruction appears at stage k exactly k+1 cycles after acceptance, plus the mem_stall cycles spent at stages <= STALL_STAGE.
- retire_cnt increments on each posedge where out_v=1; bubble_cnt increments on each posedge where dep_stall=1 AND mem_stall=0 AND flush=0. Both saturate at all-ones and are cleared by reset only.
- de_v=0 never stalls. A self-dependency (de_drid==de_sr1) never stalls on its own.

Test Plan:
1. Reset then 4 accepted independent instructions (ld_reg=1, drid 0..3, sources 4..7) -> dep_stall=0 throughout; each instruction has out_v=1 in its 4th cycle after acceptance (stage 2); retire_cnt=4.
2. Instruction A writes R2, then B reads sr1=R2 (SR_BYPASS=0) -> dep_stall=1 for 3 cycles; bubble_cnt=3; B accepted in the cycle A leaves stage 2. With SR_BYPASS=1 the stall is 2 cycles.
3. ld_cc instruction followed by BR (de_cc_needed=1, de_br=1) -> dep_stall until CC producer retires; br_stall=1 from BR decode until 1 cycle after BR leaves stage 2.
4. mem_stall held 2 cycles with stages 0,1 valid -> stages 0,1 payloads unchanged; stage 2 V=0 for 2 cycles; de_accept=0 in those cycles.
5. flush with all stages valid and mem_stall=1 -> all stage_v=0 next cycle; br_stall and dep_stall drop to 0.
6. CNT_W=4, 20 retirements -> retire_cnt stops at 15; a synchronous reset pulse mid-stream -> all V and both counters 0 on the following cycle.
